// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, frame configuration and parity helper.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   // 00=5, 01=6, 10=7, 11=8 data bits per frame
   typedef logic [1:0] data_bits_t;

   typedef struct packed {
      data_bits_t data_bits;
      logic       parity_en;
      logic       parity_odd;
      logic       stop_bits;
   } tx_cfg_t;

   localparam logic UART_IDLE_LEVEL  = 1'b1;
   localparam logic UART_START_LEVEL = 1'b0;

   // XOR of the low nbits of data, inverted for odd parity
   function automatic logic parity_calc(input logic [31:0] data,
                                        input int unsigned nbits,
                                        input logic        odd);
      logic p;
      p = odd;
      for (int unsigned i = 0; i < 32; i++) begin
         if (i < nbits) p = p ^ data[i];
      end
      return p;
   endfunction

endpackage

// File: rtl/uart_transmitter.sv
// UART transmitter: pops FWFT FIFO words and serialises them as start/data/parity/stop frames.
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  tick_i,
   input  logic                  enable_i,
   input  logic [1:0]            data_bits_i,
   input  logic                  parity_en_i,
   input  logic                  parity_odd_i,
   input  logic                  stop_bits_i,
   input  logic                  fifo_empty_i,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
   output logic                  fifo_read_o,
   output logic                  tx_o,
   output logic                  busy_o,
   output logic                  tx_done_o
);

   localparam int unsigned TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [TW-1:0] TICK_MAX = TW'(OVERSAMPLE - 1);

   tx_state_t             state;
   tx_cfg_t               cfg;
   logic [DATA_WIDTH-1:0] shreg;
   logic [DATA_WIDTH-1:0] data_q;
   logic [TW-1:0]         tick_cnt;
   logic [2:0]            bit_cnt;
   logic [2:0]            last_bit;
   logic                  bit_end;

   assign fifo_read_o = (state == IDLE) && enable_i && !fifo_empty_i;
   assign bit_end     = tick_i && (tick_cnt == TICK_MAX);
   assign last_bit    = 3'd4 + {1'b0, cfg.data_bits};

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tick_cnt <= '0;
      end else if (fifo_read_o) begin
         tick_cnt <= '0;
      end else if (tick_i) begin
         tick_cnt <= (tick_cnt == TICK_MAX) ? '0 : tick_cnt + 1'b1;
      end
   end

   // tx_o is loaded with the level of the bit that starts on this edge,
   // so the shift happens one bit ahead of what is on the line.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state     <= IDLE;
         tx_o      <= UART_IDLE_LEVEL;
         busy_o    <= 1'b0;
         tx_done_o <= 1'b0;
         bit_cnt   <= '0;
         shreg     <= '0;
         data_q    <= '0;
         cfg       <= '0;
      end else begin
         tx_done_o <= 1'b0;
         case (state)
            IDLE: begin
               tx_o <= UART_IDLE_LEVEL;
               if (fifo_read_o) begin
                  shreg  <= fifo_rd_data_i;
                  data_q <= fifo_rd_data_i;
                  cfg    <= '{data_bits:  data_bits_i,
                              parity_en:  parity_en_i,
                              parity_odd: parity_odd_i,
                              stop_bits:  stop_bits_i};
                  bit_cnt <= '0;
                  busy_o  <= 1'b1;
                  tx_o    <= UART_START_LEVEL;
                  state   <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  tx_o    <= shreg[0];
                  shreg   <= shreg >> 1;
                  bit_cnt <= '0;
                  state   <= DATA;
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_cnt == last_bit) begin
                     bit_cnt <= '0;
                     if (cfg.parity_en) begin
                        tx_o  <= parity_calc(32'(data_q), 32'(last_bit) + 32'd1, cfg.parity_odd);
                        state <= PARITY;
                     end else begin
                        tx_o  <= UART_IDLE_LEVEL;
                        state <= STOP;
                     end
                  end else begin
                     tx_o    <= shreg[0];
                     shreg   <= shreg >> 1;
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end
            end
            PARITY: begin
               if (bit_end) begin
                  tx_o    <= UART_IDLE_LEVEL;
                  bit_cnt <= '0;
                  state   <= STOP;
               end
            end
            STOP: begin
               if (bit_end) begin
                  if (cfg.stop_bits && (bit_cnt == 3'd0)) begin
                     bit_cnt <= 3'd1;
                  end else begin
                     tx_done_o <= 1'b1;
                     busy_o    <= 1'b0;
                     state     <= IDLE;
                  end
               end
            end
            default: begin
               tx_o   <= UART_IDLE_LEVEL;
               busy_o <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule
